// File: rtl/sm_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_accumulator_if
// Brief    : Request/result bundle for the sign-magnitude accumulator.
// Revision : 1.0
// ============================================================================
interface sm_accumulator_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_op;
  logic [N-1:0]  i_data;
  logic [N-1:0]  o_acc;
  logic          o_valid;
  logic          o_ovf;
  logic [CW-1:0] o_count;

  modport master (
    output i_valid, i_op, i_data,
    input  o_ready, o_acc, o_valid, o_ovf, o_count
  );

  modport slave (
    input  i_valid, i_op, i_data,
    output o_ready, o_acc, o_valid, o_ovf, o_count
  );
endinterface
`default_nettype wire

// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sm_accumulator (with sm_subtract stage)
// Brief    : Saturating sign-magnitude accumulator built on one subtract stage.
// Revision : 1.0
// ============================================================================
module sm_subtract #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] i_a,
  input  wire logic [N-1:0] i_b,
  output logic      [N-1:0] o_r,
  output logic              o_c
);
  logic         sign_a;
  logic         sign_b;
  logic [N-2:0] mag_a;
  logic [N-2:0] mag_b;
  logic [N-1:0] mag_sum;

  assign sign_a = i_a[N-1];
  assign sign_b = i_b[N-1];
  assign mag_a  = i_a[N-2:0];
  assign mag_b  = i_b[N-2:0];

  always_comb begin
    o_r     = '0;
    o_c     = 1'b0;
    mag_sum = '0;
    // Opposite signs: a - b grows in magnitude and keeps a's sign.
    if (sign_a != sign_b) begin
      mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
      o_c     = mag_sum[N-1];
      o_r     = {sign_a, mag_sum[N-2:0]};
    end else if (mag_a >= mag_b) begin
      o_r = {sign_a, mag_a - mag_b};
    end else begin
      o_r = {~sign_a, mag_b - mag_a};
    end
  end
endmodule

module sm_accumulator #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  sm_accumulator_if.slave  bus
);
  localparam logic [1:0]   OP_CLR  = 2'b00;
  localparam logic [1:0]   OP_LOAD = 2'b01;
  localparam logic [1:0]   OP_ADD  = 2'b11;
  localparam logic [N-2:0] MAG_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;

  logic          ready;
  logic [N-1:0]  sub_b;
  logic [N-1:0]  sub_r;
  logic          sub_c;
  logic [N-2:0]  res_mag;

  assign ready = (state_q == ST_IDLE) && !i_rst;

  // acc + x is computed as acc - (-x).
  assign sub_b = (op_q == OP_ADD) ? {~opnd_q[N-1], opnd_q[N-2:0]} : opnd_q;

  sm_subtract #(.N(N)) u_sub (
    .i_a (acc_q),
    .i_b (sub_b),
    .o_r (sub_r),
    .o_c (sub_c)
  );

  assign res_mag = sub_c ? MAG_MAX : sub_r[N-2:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid && ready) begin
          op_d    = bus.i_op;
          opnd_d  = bus.i_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
        case (op_q)
          OP_CLR: begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
          end
          OP_LOAD: begin
            acc_d = (opnd_q[N-2:0] == '0) ? '0 : opnd_q;
            ovf_d = 1'b0;
            cnt_d = '0;
          end
          default: begin
            // A zero magnitude always carries a positive sign.
            acc_d = (res_mag == '0) ? '0 : {sub_r[N-1], res_mag};
            if (sub_c) ovf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_acc   = acc_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_count = cnt_q;
endmodule
`default_nettype wire
